led_afterglow: RTL and testbench

LED_AFTERGLOW -- requirements
Module: led_afterglow

---
 rtl/led_pkg.sv | 7 +
 rtl/led_intensity_cell.sv | 29 ++
 rtl/led_afterglow.sv | 40 ++++
 tb/tb_led_afterglow.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared LED channel constants and intensity type.
package led_pkg;
    localparam int NLED = 8;
    localparam int IBITS = 4;
    localparam logic [IBITS-1:0] IMAX = '1;
    typedef logic [IBITS-1:0] intensity_t;
endpackage

// File: rtl/led_intensity_cell.sv
// led_intensity_cell: one LED's afterglow intensity with load/decay/saturate and PWM output flop.
module led_intensity_cell #(
    parameter int IBITS = led_pkg::IBITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             decay_stb,
    input  logic [IBITS-1:0] pwm_cnt,
    output logic             led
);
    localparam logic [IBITS-1:0] IMAX = '1;
    logic [IBITS-1:0] intensity;
    logic [IBITS-1:0] intensity_nx;
    // a fresh eye hit outranks the decay strobe; decay stops at zero
    always_comb intensity_nx = load ? IMAX
                             : (decay_stb && intensity != '0) ? intensity - 1'b1
                             : intensity;
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            intensity <= '0;
            led <= 1'b0;
        end else begin
            intensity <= intensity_nx;
            led <= (intensity == IMAX) || (intensity > pwm_cnt);
        end
    end
endmodule

// File: rtl/led_afterglow.sv
// led_afterglow: cylon eye pattern with per-LED fading afterglow driven by shared PWM and decay prescaler.
module led_afterglow #(
    parameter int MXPRE = 18,
    parameter int NLED  = led_pkg::NLED,
    parameter int IBITS = led_pkg::IBITS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [NLED-1:0] pattern_in,
    input  logic [1:0]      decay_rate,
    output logic [NLED-1:0] led_out
);
    logic [NLED-1:0]  pattern_r;
    logic [IBITS-1:0] pwm_cnt;
    logic [MXPRE-1:0] prescaler;
    logic [MXPRE:0]   pre_sum;
    logic             decay_stb;
    // the carry out of the prescaler accumulator is the decay strobe
    always_comb begin
        pre_sum = {1'b0, prescaler} + (MXPRE+1)'(decay_rate) + 1'b1;
        decay_stb = enable && pre_sum[MXPRE];
    end
    always_ff @(posedge clock) begin
        pattern_r <= reset ? '0 : pattern_in;
        pwm_cnt <= (reset || !enable) ? '0 : pwm_cnt + 1'b1;
        prescaler <= (reset || !enable) ? '0 : pre_sum[MXPRE-1:0];
    end
    for (genvar i = 0; i < NLED; i++) begin : g_cell
        led_intensity_cell #(.IBITS(IBITS)) u_cell (
            .clock(clock),
            .reset(reset),
            .enable(enable),
            .load(pattern_r[i]),
            .decay_stb(decay_stb),
            .pwm_cnt(pwm_cnt),
            .led(led_out[i])
        );
    end
endmodule

// File: tb/tb_led_afterglow.sv
// tb_led_afterglow: table-driven and hand-sequenced checks of led_afterglow against a cycle model.
module tb_led_afterglow;
    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] pattern_in;
    logic [1:0] decay_rate;
    logic [7:0] led_out;

    led_afterglow #(.MXPRE(3), .NLED(8), .IBITS(4)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .pattern_in(pattern_in),
        .decay_rate(decay_rate),
        .led_out(led_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] pat;
        logic [1:0] rate;
        int         n;
        logic       chk;
        logic [7:0] exp_led;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_pr = '0;
    logic [3:0] m_pwm = '0;
    logic [2:0] m_pre = '0;
    led_pkg::intensity_t m_int[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle, advance the model, push its expectation, then pop and compare
    task automatic step(input logic r, input logic e, input logic [7:0] p, input logic [1:0] dr);
        logic [3:0] s;
        logic [7:0] nl;
        logic [7:0] exp;
        reset = r;
        enable = e;
        pattern_in = p;
        decay_rate = dr;
        s = 4'(m_pre) + 4'(dr) + 4'd1;
        for (int i = 0; i < 8; i++)
            nl[i] = !r && e && (m_int[i] == 4'd15 || m_int[i] > m_pwm);
        for (int i = 0; i < 8; i++) begin
            if (r || !e) m_int[i] = 4'd0;
            else if (m_pr[i]) m_int[i] = 4'd15;
            else if (s[3] && m_int[i] != 4'd0) m_int[i] = m_int[i] - 4'd1;
        end
        m_pwm = (r || !e) ? 4'd0 : m_pwm + 4'd1;
        m_pre = (r || !e) ? 3'd0 : s[2:0];
        m_pr = r ? 8'h00 : p;
        exp_q.push_back(nl);
        @(posedge clock);
        #1;
        exp = exp_q.pop_front();
        check("led_out_cycle", led_out, exp);
    endtask

    vec_t vecs[10];

    initial begin
        for (int i = 0; i < 8; i++) m_int[i] = '0;
        reset = 1'b1;
        enable = 1'b0;
        pattern_in = '0;
        decay_rate = '0;
        vecs[0] = '{1'b1, 1'b1, 8'hFF, 2'd0, 4,  1'b1, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'hFF, 2'd0, 3,  1'b1, 8'hFF};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 2'd0, 40, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 2'd0, 1,  1'b1, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 2'd0, 20, 1'b1, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h41, 2'd3, 12, 1'b1, 8'h41};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 2'd2, 50, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 8'hA5, 2'd1, 5,  1'b0, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 2'd1, 30, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 1'b1, 8'hFF, 2'd3, 4,  1'b1, 8'hFF};
        for (int v = 0; v < 10; v++) begin
            for (int c = 0; c < vecs[v].n; c++)
                step(vecs[v].rst, vecs[v].en, vecs[v].pat, vecs[v].rate);
            if (vecs[v].chk) check($sformatf("vec%0d_end", v), led_out, vecs[v].exp_led);
        end

        for (int c = 0; c < 300; c++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 19) != 0,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 2'($urandom));

        // rate 3: one load, dark exactly 30 clocks later
        step(1'b1, 1'b1, 8'h00, 2'd3);
        step(1'b0, 1'b1, 8'h01, 2'd3);
        step(1'b0, 1'b1, 8'h00, 2'd3);
        check("r3_loaded", 8'(dut.g_cell[0].u_cell.intensity), 8'd15);
        for (int c = 0; c < 29; c++) step(1'b0, 1'b1, 8'h00, 2'd3);
        check("r3_last_glow", 8'(dut.g_cell[0].u_cell.intensity), 8'd1);
        step(1'b0, 1'b1, 8'h00, 2'd3);
        check("r3_dark", 8'(dut.g_cell[0].u_cell.intensity), 8'd0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 8'h00, 2'd3);
        check("r3_saturate", 8'(dut.g_cell[0].u_cell.intensity), 8'd0);

        // rate 0: first decrement 6 clocks after load, then every 8
        step(1'b1, 1'b1, 8'h00, 2'd0);
        step(1'b0, 1'b1, 8'h01, 2'd0);
        step(1'b0, 1'b1, 8'h00, 2'd0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 8'h00, 2'd0);
        check("r0_first_decay", 8'(dut.g_cell[0].u_cell.intensity), 8'd14);
        for (int c = 0; c < 111; c++) step(1'b0, 1'b1, 8'h00, 2'd0);
        check("r0_last_glow", 8'(dut.g_cell[0].u_cell.intensity), 8'd1);
        step(1'b0, 1'b1, 8'h00, 2'd0);
        check("r0_dark", 8'(dut.g_cell[0].u_cell.intensity), 8'd0);

        // reset in the middle of LED3's decay
        step(1'b1, 1'b1, 8'h00, 2'd3);
        step(1'b0, 1'b1, 8'h08, 2'd3);
        for (int k = 0; k < 60 && m_int[3] != 4'd7; k++) step(1'b0, 1'b1, 8'h00, 2'd3);
        check("mid_decay_i3", 8'(dut.g_cell[3].u_cell.intensity), 8'd7);
        step(1'b1, 1'b1, 8'h08, 2'd3);
        check("reset_i3", 8'(dut.g_cell[3].u_cell.intensity), 8'd0);
        check("reset_led", led_out, 8'h00);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 8'h00, 2'd3);
        check("post_reset_i3", 8'(dut.g_cell[3].u_cell.intensity), 8'd0);
        check("post_reset_led", led_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
